uart_frame_decoder: RTL
=======================

# uart_frame_decoder

- Consumes the byte stream from the UART receiver: one `rx_valid` pulse with `rx_data`.
- Parses fixed 4-byte write frames: SYNC, ADDR, DATA, CHK.
- Commits each valid frame into a small internal register bank that drives board-level logic (LEDs, 7-segment).
- Rejects malformed frames and reports the reason.
- Sequences and times out the receiver's output, so a lost byte never leaves the parser stuck mid-frame.

## Interface

Parameters:
- `NUM_REGS`, default 4: number of 8-bit registers; legal range 2..16.
- `TIMEOUT_CLKS`, default 4_545_460: maximum gap between bytes of one frame (about 1 byte time at 110 baud, 50 MHz), in clocks.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_valid`, input, 1: one-cycle strobe from the receiver; at least 2 idle cycles between strobes.
- `rx_data`, input, 8: received byte; valid when `rx_valid` = 1.
- `wr_stb`, output, 1: one-cycle pulse; a register was written.
- `wr_addr`, output, $clog2(NUM_REGS): address of the last committed write.
- `regs`, output, NUM_REGS*8: register bank; reg i is at bits [8i+7:8i].
- `err_stb`, output, 1: one-cycle pulse; a frame was rejected.
- `err_code`, output, 2: last error: 0 none, 1 checksum, 2 address, 3 timeout.
- `frame_count`, output, 8: count of committed frames; wraps 255 -> 0.

## Operation

- States: `WAIT_SYNC`, `GET_ADDR`, `GET_DATA`, `GET_CHK`.
- `WAIT_SYNC`:
  - `rx_valid` with byte 0xA5 -> `GET_ADDR`.
  - Any other byte is dropped silently, with no error.
- `GET_ADDR`: `rx_valid` latches ADDR -> `GET_DATA`.
- `GET_DATA`: `rx_valid` latches DATA -> `GET_CHK`.
- `GET_CHK`: on `rx_valid`, evaluate the checks in priority order:
  1. If CHK != (ADDR + DATA) mod 256 -> err_code 1.
  2. Else if ADDR >= NUM_REGS -> err_code 2.
  3. Otherwise commit: `regs[ADDR]` <= DATA, `wr_addr` <= ADDR, `wr_stb` pulse, `frame_count` + 1.
  - Always return to `WAIT_SYNC`.
- A byte value of 0xA5 in ADDR, DATA or CHK position is ordinary data; there is no resynchronisation mid-frame.
- Gap timer:
  - Clears on every `rx_valid` and while in `WAIT_SYNC`; otherwise increments.
  - Reaching TIMEOUT_CLKS-1 outside `WAIT_SYNC` -> err_code 3, `err_stb` pulse, -> `WAIT_SYNC`, partial frame discarded.
- Simultaneous `rx_valid` and timer terminal count: the byte wins; it is processed normally and no timeout is raised.
- `err_code` holds its value until the next error. A successful commit does not clear it.
- Address width: ADDR is compared as the full 8 bits; `wr_addr` takes the low $clog2(NUM_REGS) bits.
- Reset values: state `WAIT_SYNC`, all `regs` 0, `wr_addr` 0, `wr_stb` 0, `err_stb` 0, `err_code` 0, `frame_count` 0, timer 0.
- Reset asserted mid-frame: partial frame lost; no strobe is generated on release.

## Timing

- All outputs are registered. There are no combinational paths from inputs to outputs.
- Byte k is sampled at the rising edge where `rx_valid` = 1 (edge n).
- Commit latency:
  - At edge n of the CHK byte, `regs`, `wr_addr` and `frame_count` update and `wr_stb` goes high.
  - `wr_stb` is visible in cycle n+1 and drops at edge n+1.
- Error latency:
  - `err_stb` and `err_code` update at the same edge as the CHK byte or the terminal count.
  - `err_stb` is high for exactly one cycle.
- `wr_stb` and `err_stb` are never high together.
- Back-to-back frames need no idle time. A SYNC byte may arrive 2 cycles after a commit.
- Timeout fires exactly TIMEOUT_CLKS cycles after the last accepted in-frame byte.

## Structure

- Shared package `uart_pkg` holds:
  - `SYNC_BYTE` = 8'hA5.
  - The state enum `frame_state_t`.
  - The error-code enum `frame_err_t` (ERR_NONE, ERR_CHK, ERR_ADDR, ERR_TIMEOUT).
- Sub-module `uart_gap_timer`:
  - Parameter `TIMEOUT_CLKS`.
  - Inputs `clr`, `en`; output `expired` (registered, one-cycle).
  - Counter width $clog2(TIMEOUT_CLKS).
- The register bank and FSM stay in `uart_frame_decoder`.

## Test plan

Use NUM_REGS=4 and TIMEOUT_CLKS=100 for simulation.

- Frame A5 02 3C 3E -> `wr_stb` pulse 1 cycle, `wr_addr`=2, `regs`[23:16]=0x3C, `frame_count`=1, `err_code`=0.
- Frame A5 01 10 FF -> `err_stb` pulse, `err_code`=1, `regs` unchanged, `frame_count` unchanged.
- Frame A5 05 01 06 -> `err_code`=2, no `wr_stb`.
- Send A5 03, then wait 100 cycles -> `err_stb` at the 100th cycle after the 03 byte, `err_code`=3.
  - Follow with A5 03 7F 82 -> `regs`[31:24]=0x7F.
- Noise bytes 00 FF 5A before A5 00 A5 A5 -> no `err_stb`, `regs`[7:0]=0xA5 (0xA5 accepted as DATA).
- Assert `rst_n` low after A5 01 -> all outputs 0. Then 256 good frames -> `frame_count` wraps to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART frame decoder: sync marker, parser states, error codes.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GET_ADDR  = 2'd1,
    GET_DATA  = 2'd2,
    GET_CHK   = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_ADDR    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } frame_err_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer; expired is a registered one-cycle flag that is high
// during the cycle in which the count sits at TIMEOUT_CLKS-1.
`timescale 1ns/1ps
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CLKS = 4_545_460
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CLKS);

  logic [CW-1:0] count_q;

  // Flag is raised one edge early so the parser acts on the terminal-count edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clr || !en || expired) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_q + CW'(1);
      expired <= (count_q == CW'(TIMEOUT_CLKS - 2));
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses SYNC/ADDR/DATA/CHK write frames from a UART byte stream into a small
// register bank, reporting checksum, address and inter-byte timeout errors.
`timescale 1ns/1ps
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned TIMEOUT_CLKS = 4_545_460
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [NUM_REGS*8-1:0]       regs,
  output logic                        err_stb,
  output logic [1:0]                  err_code,
  output logic [7:0]                  frame_count
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  frame_state_t          state_q, state_d;
  frame_err_t            err_q, err_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [7:0]            fc_q, fc_d;
  logic                  wr_stb_q, wr_stb_d;
  logic                  err_stb_q, err_stb_d;
  logic                  timer_clr, timer_en, timer_expired;

  assign timer_en  = (state_q != WAIT_SYNC);
  assign timer_clr = rx_valid || (state_q == WAIT_SYNC);

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_SYNC;
      err_q     <= ERR_NONE;
      addr_q    <= '0;
      data_q    <= '0;
      regs_q    <= '0;
      waddr_q   <= '0;
      fc_q      <= '0;
      wr_stb_q  <= 1'b0;
      err_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      regs_q    <= regs_d;
      waddr_q   <= waddr_d;
      fc_q      <= fc_d;
      wr_stb_q  <= wr_stb_d;
      err_stb_q <= err_stb_d;
    end
  end

  // A byte arriving on the terminal-count edge takes precedence over the timeout.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    addr_d    = addr_q;
    data_d    = data_q;
    regs_d    = regs_q;
    waddr_d   = waddr_q;
    fc_d      = fc_q;
    wr_stb_d  = 1'b0;
    err_stb_d = 1'b0;

    if (rx_valid) begin
      case (state_q)
        WAIT_SYNC: begin
          if (rx_data == SYNC_BYTE) state_d = GET_ADDR;
        end
        GET_ADDR: begin
          addr_d  = rx_data;
          state_d = GET_DATA;
        end
        GET_DATA: begin
          data_d  = rx_data;
          state_d = GET_CHK;
        end
        GET_CHK: begin
          state_d = WAIT_SYNC;
          if (rx_data != 8'(addr_q + data_q)) begin
            err_stb_d = 1'b1;
            err_d     = ERR_CHK;
          end else if (addr_q >= 8'(NUM_REGS)) begin
            err_stb_d = 1'b1;
            err_d     = ERR_ADDR;
          end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (addr_q[AW-1:0] == AW'(i)) regs_d[i*8 +: 8] = data_q;
            end
            waddr_d  = addr_q[AW-1:0];
            wr_stb_d = 1'b1;
            fc_d     = fc_q + 8'd1;
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end else if (timer_expired && (state_q != WAIT_SYNC)) begin
      state_d   = WAIT_SYNC;
      err_stb_d = 1'b1;
      err_d     = ERR_TIMEOUT;
    end
  end

  assign wr_stb      = wr_stb_q;
  assign wr_addr     = waddr_q;
  assign regs        = regs_q;
  assign err_stb     = err_stb_q;
  assign err_code    = 2'(err_q);
  assign frame_count = fc_q;

endmodule
